imem_loader: RTL and testbench

//  Writer side of the instruction-memory interface: streams a program into imem

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 116 +++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// imem_loader_if: word-stream handshake plus imem write port between a program source and the loader.
// Widths default to the `ASIZE / `ISIZE macros when those are not supplied by the build.
`ifndef ASIZE
`define ASIZE 4
`endif
`ifndef ISIZE
`define ISIZE 32
`endif
interface imem_loader_if #(
  parameter int ASIZE = `ASIZE,
  parameter int ISIZE = `ISIZE
);
  logic             in_valid;
  logic [ISIZE-1:0] in_data;
  logic             in_last;
  logic             in_ready;
  logic             mem_we;
  logic [ASIZE-1:0] mem_addr;
  logic [ISIZE-1:0] mem_wdata;
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: streams a program into imem and holds the CPU in reset until the load completes.
// Optional LOADER_CHECKSUM_EN adds a trailing XOR checksum word and a csum output.
`ifndef ASIZE
`define ASIZE 4
`endif
`ifndef ISIZE
`define ISIZE 32
`endif
module imem_loader #(
  parameter int ASIZE = `ASIZE,
  parameter int ISIZE = `ISIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  imem_loader_if.slave     bus,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [ASIZE:0]   word_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [ISIZE-1:0] csum
`endif
);
  localparam logic [ASIZE:0] LAST_PTR = (ASIZE+1)'((1 << ASIZE) - 1);
  typedef enum logic [2:0] {IDLE, LOAD, DONE, ERROR, CSUM} state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
`else
  localparam state_t END_ST = DONE;
`endif
  state_t           state_q, state_d;
  logic [ASIZE:0]   ptr_q, ptr_d;
  logic             we_q, we_d;
  logic [ASIZE-1:0] addr_q, addr_d;
  logic [ISIZE-1:0] wdata_q, wdata_d;
  logic             accept;
`ifdef LOADER_CHECKSUM_EN
  logic [ISIZE-1:0] csum_q, csum_d;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    accept  = bus.in_valid & bus.in_ready;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = '0;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = ptr_q[ASIZE-1:0];
          wdata_d = bus.in_data;
          ptr_d   = ptr_q + 1'b1;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.in_data;
`endif
          // The word at the top address is written; only a stream that keeps going past it fails.
          state_d = bus.in_last ? END_ST : (ptr_q == LAST_PTR) ? ERROR : LOAD;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: if (accept) state_d = (bus.in_data == csum_q) ? DONE : ERROR;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.in_ready  = (state_q == LOAD) || (state_q == CSUM);
    bus.mem_we    = we_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    // Hold done back while the final write strobe is still in flight.
    done          = (state_q == DONE) && !we_q;
    error         = state_q == ERROR;
    cpu_hold      = !done;
    word_count    = ptr_q;
`ifdef LOADER_CHECKSUM_EN
    csum          = csum_q;
`endif
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the imem loader handshake, write timing, overflow and reset.
module tb_imem_loader;
  localparam int ASIZE = 4;
  localparam int ISIZE = 32;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, done, error;
  logic [ASIZE:0] word_count;
`ifdef LOADER_CHECKSUM_EN
  logic [ISIZE-1:0] csum;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  int nwr = 0;
  int wbase = 0;
  int n0;
  logic [ISIZE-1:0] xr;
  logic [ISIZE-1:0] img [16];
  logic [ISIZE-1:0] words [4];
  imem_loader_if #(.ASIZE(ASIZE), .ISIZE(ISIZE)) bus ();
  imem_loader #(.ASIZE(ASIZE), .ISIZE(ISIZE)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .bus(bus),
    .cpu_hold(cpu_hold),
    .done(done),
    .error(error),
`ifdef LOADER_CHECKSUM_EN
    .csum(csum),
`endif
    .word_count(word_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.mem_we) begin
      img[bus.mem_addr] = bus.mem_wdata;
      nwr++;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic begin_load();
    start = 1'b1;
    step();
    start = 1'b0;
    xr = '0;
    wbase = nwr;
  endtask
  task automatic send(input logic [ISIZE-1:0] d, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_last = last;
    step();
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    xr = xr ^ d;
  endtask
  task automatic close();
`ifdef LOADER_CHECKSUM_EN
    bus.in_valid = 1'b1;
    bus.in_data = xr;
`endif
    step();
    bus.in_valid = 1'b0;
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_last = 1'b0;
    words[0] = 32'h11; words[1] = 32'h22; words[2] = 32'h33; words[3] = 32'h44;
    step();
    step();
    check("rst_ready", bus.in_ready, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_wc", word_count, 0);
    rst = 1'b0;
    step();
    check("idle_ready", bus.in_ready, 0);
    // back-to-back stream
    begin_load();
    check("b2b_ready", bus.in_ready, 1);
    check("b2b_hold_load", cpu_hold, 1);
    for (int i = 0; i < 4; i++) begin
      send(words[i], i == 3);
      check($sformatf("b2b_we%0d", i), bus.mem_we, 1);
      check($sformatf("b2b_addr%0d", i), bus.mem_addr, i);
      check($sformatf("b2b_data%0d", i), bus.mem_wdata, words[i]);
    end
    check("b2b_done_masked", done, 0);
    check("b2b_hold_masked", cpu_hold, 1);
`ifndef LOADER_CHECKSUM_EN
    check("b2b_ready_after", bus.in_ready, 0);
`endif
    close();
    check("b2b_done", done, 1);
    check("b2b_hold", cpu_hold, 0);
    check("b2b_wc", word_count, 4);
    check("b2b_we_off", bus.mem_we, 0);
    check("b2b_nwr", nwr - wbase, 4);
    // gapped stream
    begin_load();
    check("gap_hold_restart", cpu_hold, 1);
    check("gap_done_clear", done, 0);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        step();
        check($sformatf("gap_idle_a%0d", i), bus.mem_we, 0);
        step();
        check($sformatf("gap_idle_b%0d", i), bus.mem_we, 0);
      end
      send(words[i], i == 3);
      check($sformatf("gap_we%0d", i), bus.mem_we, 1);
      check($sformatf("gap_addr%0d", i), bus.mem_addr, i);
      check($sformatf("gap_data%0d", i), bus.mem_wdata, words[i]);
    end
    close();
    check("gap_done", done, 1);
    check("gap_wc", word_count, 4);
    check("gap_nwr", nwr - wbase, 4);
    // start while loading is ignored
    begin_load();
    send(32'h55, 1'b0);
    send(32'h66, 1'b0);
    start = 1'b1;
    step();
    check("ign_ready", bus.in_ready, 1);
    check("ign_wc", word_count, 2);
    send(32'h77, 1'b0);
    check("ign_addr", bus.mem_addr, 2);
    check("ign_wc3", word_count, 3);
    start = 1'b0;
    send(32'h88, 1'b1);
    check("ign_addr3", bus.mem_addr, 3);
    close();
    check("ign_done", done, 1);
    check("ign_wc4", word_count, 4);
    check("ign_img0", img[0], 32'h55);
    check("ign_img3", img[3], 32'h88);
    // async reset mid-stream
    begin_load();
    send(32'h1, 1'b0);
    send(32'h2, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data = 32'h3;
    step();
    check("mid_we_pre", bus.mem_we, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_we", bus.mem_we, 0);
    check("mid_hold", cpu_hold, 1);
    check("mid_wc", word_count, 0);
    check("mid_ready", bus.in_ready, 0);
    n0 = nwr;
    step();
    step();
    rst = 1'b0;
    step();
    step();
    bus.in_valid = 1'b0;
    check("mid_nowrite", nwr, n0);
    check("mid_idle_ready", bus.in_ready, 0);
    check("mid_done", done, 0);
    // overflow: DEPTH words without in_last
    begin_load();
    for (int i = 0; i < 16; i++) send(32'(i * 7 + 3), 1'b0);
    check("ovf_we_last", bus.mem_we, 1);
    check("ovf_addr_last", bus.mem_addr, 15);
    check("ovf_error_now", error, 1);
    check("ovf_ready", bus.in_ready, 0);
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDEAD;
    step();
    check("ovf_error", error, 1);
    check("ovf_hold", cpu_hold, 1);
    check("ovf_done", done, 0);
    check("ovf_wc", word_count, 16);
    step();
    bus.in_valid = 1'b0;
    check("ovf_nwr", nwr - wbase, 16);
    check("ovf_img0", img[0], 3);
    check("ovf_img15", img[15], 108);
    // recovery with a one-word program
    begin_load();
    check("rec_error_clr", error, 0);
    send(32'hAB, 1'b1);
    close();
    check("rec_done", done, 1);
    check("rec_error", error, 0);
    check("rec_wc", word_count, 1);
    check("rec_img0", img[0], 32'hAB);
`ifdef LOADER_CHECKSUM_EN
    begin_load();
    check("cs_clear", csum, 0);
    send(32'h0F, 1'b0);
    send(32'hF0, 1'b1);
    check("cs_run", csum, 32'hFF);
    check("cs_ready", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_data = 32'hFF;
    step();
    bus.in_valid = 1'b0;
    check("cs_ok_done", done, 1);
    check("cs_ok_nwr", nwr - wbase, 2);
    begin_load();
    check("cs_clear2", csum, 0);
    send(32'h0F, 1'b0);
    send(32'hF0, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_data = 32'hFE;
    step();
    bus.in_valid = 1'b0;
    check("cs_bad_error", error, 1);
    check("cs_bad_hold", cpu_hold, 1);
    check("cs_bad_done", done, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
